// File: rtl/decoder_seq.sv
// Handshaked op decoder: accepts one op when idle, holds alu_op/flags for HOLD_CYCLES cycles,
// counts retired ops (saturating) and latches sticky halt/fault status until reset.
module decoder_seq #(
  parameter int OP_W        = 4,
  parameter int ALU_OP_W    = 2,
  parameter int FLAGS_W     = 6,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OP_W-1:0]     op,
  input  logic                op_valid,
  output logic                op_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [0:FLAGS_W-1]  flags,
  output logic                flags_valid,
  output logic                halted,
  output logic                fault,
  output logic [OP_W-1:0]     fault_op,
  output logic [CNT_W-1:0]    retired
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALTED, S_FAULT} state_e;

  state_e              state_q, state_d;
  logic [HW-1:0]       cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] alu_q, alu_d;
  logic [0:FLAGS_W-1]  flags_q, flags_d;
  logic                fv_q, fv_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic [OP_W-1:0]     fault_op_q, fault_op_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                rdy_q, rdy_d;

  logic                dec_halt, dec_legal, dec_fv;
  logic [ALU_OP_W-1:0] dec_alu;
  logic [5:0]          dec_f6;
  logic [0:FLAGS_W-1]  dec_flags;
  logic                xfer;

  // Opcode decode; the 6-bit encoding fills flags[0:5], wider flag vectors stay 0 above that.
  always_comb begin
    dec_halt  = 1'b0;
    dec_legal = 1'b1;
    dec_fv    = 1'b1;
    dec_alu   = '0;
    dec_f6    = 6'b000000;
    case (32'(op))
      0:  dec_halt = 1'b1;
      1:  dec_fv   = 1'b0;
      2:  dec_f6   = 6'b010100;
      3:  dec_f6   = 6'b101110;
      4:  dec_f6   = 6'b111111;
      5:  dec_f6   = 6'b110110;
      6:  begin dec_alu = ALU_OP_W'(1); dec_f6 = 6'b111111; end
      7:  begin dec_alu = ALU_OP_W'(1); dec_f6 = 6'b110110; end
      8:  begin dec_alu = ALU_OP_W'(2); dec_f6 = 6'b111111; end
      9:  begin dec_alu = ALU_OP_W'(2); dec_f6 = 6'b110110; end
      10: begin dec_alu = ALU_OP_W'(3); dec_f6 = 6'b111111; end
      11: begin dec_alu = ALU_OP_W'(3); dec_f6 = 6'b110110; end
      default: begin dec_legal = 1'b0; dec_fv = 1'b0; end
    endcase
    dec_flags      = '0;
    dec_flags[0:5] = dec_f6;
  end

  assign xfer = op_valid & rdy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_d      = alu_q;
    flags_d    = flags_q;
    fv_d       = fv_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    fault_op_d = fault_op_q;
    retired_d  = retired_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (dec_halt) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else if (!dec_legal) begin
            state_d    = S_FAULT;
            fault_d    = 1'b1;
            fault_op_d = op;
          end else begin
            state_d = S_EXEC;
            cnt_d   = HW'(HOLD_CYCLES - 1);
            alu_d   = dec_alu;
            flags_d = dec_flags;
            fv_d    = dec_fv;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          alu_d   = '0;
          flags_d = '0;
          fv_d    = 1'b0;
          if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  // op_ready is registered, so it stays low through reset and rises one edge after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_q      <= '0;
      flags_q    <= '0;
      fv_q       <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      fault_op_q <= '0;
      retired_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_q      <= alu_d;
      flags_q    <= flags_d;
      fv_q       <= fv_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      fault_op_q <= fault_op_d;
      retired_q  <= retired_d;
      rdy_q      <= rdy_d;
    end
  end

  assign op_ready    = rdy_q;
  assign alu_op      = alu_q;
  assign flags       = flags_q;
  assign flags_valid = fv_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fault_op    = fault_op_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: directed scenarios then random ops/resets, checked against an
// output-timeline model (queue of expected EXEC cycles per accepted op).
`timescale 1ns/1ps
module tb_decoder_seq;

  localparam int OP_W = 4;
  localparam int HOLD = 2;
  localparam int CW   = 3;
  localparam int RMAX = (1 << CW) - 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [1:0]      alu_op;
  logic [0:5]      flags;
  logic            flags_valid, halted, fault;
  logic [OP_W-1:0] fault_op;
  logic [CW-1:0]   retired;

  decoder_seq #(.OP_W(OP_W), .ALU_OP_W(2), .FLAGS_W(6), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .alu_op(alu_op), .flags(flags), .flags_valid(flags_valid), .halted(halted), .fault(fault),
    .fault_op(fault_op), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    int alu;
    int fl;
    bit fv;
  } ent_t;

  ent_t m_q[$];
  int   m_ret, m_fop;
  bit   m_halt, m_fault, m_live, m_xfer;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_live && (m_q.size() == 0) && !m_halt && !m_fault;
  endfunction

  task automatic check_all();
    ent_t e;
    e = '{alu: 0, fl: 0, fv: 1'b0};
    if (m_q.size() > 0) e = m_q[0];
    chk("op_ready", 32'(op_ready), 32'(m_ready()));
    chk("alu_op", 32'(alu_op), e.alu);
    chk("flags", 32'(flags), e.fl);
    chk("flags_valid", 32'(flags_valid), 32'(e.fv));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_op", 32'(fault_op), m_fop);
    chk("retired", 32'(retired), m_ret);
  endtask

  // Model of one rising edge, using the inputs the bench is driving.
  task automatic step();
    ent_t e;
    int   o;
    m_xfer = op_valid && m_ready();
    o = int'(op);
    if (m_q.size() > 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0 && m_ret < RMAX) m_ret++;
    end else if (m_xfer) begin
      if (o == 0) m_halt = 1'b1;
      else if (o > 11) begin
        m_fault = 1'b1;
        m_fop   = o;
      end else begin
        if (o == 1)      e = '{alu: 0, fl: 0, fv: 1'b0};
        else if (o == 2) e = '{alu: 0, fl: 'b010100, fv: 1'b1};
        else if (o == 3) e = '{alu: 0, fl: 'b101110, fv: 1'b1};
        else e = '{alu: (o - 4) / 2, fl: (o % 2 == 0) ? 'b111111 : 'b110110, fv: 1'b1};
        for (int i = 0; i < HOLD; i++) m_q.push_back(e);
      end
    end
    m_live = 1'b1;
  endtask

  task automatic cycle(input bit v, input int o);
    @(negedge clock);
    check_all();
    op_valid = v;
    op       = OP_W'(o);
    @(posedge clock);
    step();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    op_valid = 1'b0;
    m_q.delete();
    m_ret = 0; m_fop = 0; m_halt = 1'b0; m_fault = 1'b0; m_live = 1'b0; m_xfer = 1'b0;
    #1 check_all();
    @(negedge clock);
    check_all();
    reset_n = 1'b1;
    @(posedge clock);
    step();
  endtask

  task automatic send(input int o);
    m_xfer = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, o);
      if (m_xfer) break;
    end
    if (!m_xfer) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  initial begin
    int r, o;
    @(posedge clock);
    do_reset();
    idle(10);
    send(5);
    idle(4);
    do_reset();
    send(2); send(3); send(1); send(6); send(10);
    idle(4);
    do_reset();
    send(4); send(5); send(0);
    for (int i = 0; i < 10; i++) cycle(1'b1, $urandom_range(1, 11));
    do_reset();
    send(13);
    idle(4);
    do_reset();
    send(7);
    do_reset();
    idle(2);
    for (int i = 0; i < 9; i++) send(1);
    idle(5);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 31);
      if (r < 28) o = 1 + (r % 11);
      else o = $urandom_range(0, 15);
      if ($urandom_range(0, 199) == 0 || ((m_halt || m_fault) && $urandom_range(0, 7) == 0))
        do_reset();
      else
        cycle($urandom_range(0, 3) != 0, o);
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised, handshaked successor to the single-cycle op decoder.
- Accepts one instruction per op_valid/op_ready transfer and drives alu_op/flags to the datapath for HOLD_CYCLES cycles, then releases them.
- Halt and illegal ops are reported as sticky status outputs instead of ending simulation.
- Maintains a saturating retired-instruction counter. Sits between the fetch stage and the register file/ALU.

Parameters:
- OP_W, 4, instruction opcode width; minimum 3.
- ALU_OP_W, 2, ALU operation select width; minimum 2.
- FLAGS_W, 6, control-flag vector width; minimum 6.
- HOLD_CYCLES, 2, cycles that flags/alu_op stay asserted per executed op; minimum 1.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- op, input, OP_W, instruction opcode; sampled only on a transfer.
- op_valid, input, 1, op is presented.
- op_ready, output, 1, decoder can accept an op this cycle.
- alu_op, output, ALU_OP_W, ALU select: 0=add, 1=sub, 2=and, 3=or.
- flags, output, [0:FLAGS_W-1], datapath control flags; index 0 is the leftmost bit in the encodings below.
- flags_valid, output, 1, alu_op/flags are meaningful this cycle.
- halted, output, 1, sticky; a halt was executed.
- fault, output, 1, sticky; an illegal op was received.
- fault_op, output, OP_W, opcode that caused the fault.
- retired, output, CNT_W, count of completed non-halt, non-fault ops.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - alu_op, flags, flags_valid, halted, fault, fault_op and retired all go to 0.
  - op_ready goes to 0 while reset is asserted and to 1 in the first cycle after release.
  - Reset mid-EXEC aborts the op and does not count it.
- States: IDLE, EXEC, HALTED, FAULT.
- op_ready = 1 only in IDLE. A transfer is op_valid & op_ready at a rising edge.
- IDLE transitions on a transfer, decoding the captured op:
  - 0 halt: go to HALTED; halted=1 from the next cycle.
  - 1 nop: go to EXEC; flags_valid=0, flags=0.
  - 2 set: EXEC, flags=010100, alu_op=0.
  - 3 copy: EXEC, flags=101110, alu_op=0.
  - 4 addr: EXEC, alu_op=0, flags=111111.
  - 5 addv: EXEC, alu_op=0, flags=110110.
  - 6 subr: EXEC, alu_op=1, flags=111111.
  - 7 subv: EXEC, alu_op=1, flags=110110.
  - 8 andr / 9 andv: alu_op=2, with flags as for addr / addv.
  - 10 orr / 11 orv: alu_op=3, with flags as for addr / addv.
  - Codes 8-11 exist only when OP_W>=4.
  - Any other code: go to FAULT; fault=1 and fault_op=op from the next cycle.
  - When FLAGS_W>6, the extra flag bits are 0.
- EXEC:
  - Lasts exactly HOLD_CYCLES cycles. The first EXEC cycle immediately follows the transfer edge (latency 1).
  - alu_op and flags are held stable throughout. flags_valid=1 for every op except nop.
  - On the last EXEC cycle's edge: go to IDLE, set alu_op/flags/flags_valid to 0, and increment retired (nop included).
- Throughput: one op per HOLD_CYCLES+1 cycles. An op_valid held high through EXEC is accepted on the first IDLE cycle.
- retired saturates at all-ones; it never wraps.
- HALTED and FAULT:
  - Terminal until reset; op_ready=0 and op_valid is ignored.
  - Outputs stay 0 except the status outputs.
  - halted and fault are never both 1.
- op_valid while op_ready=0 is ignored; no buffering. The source must hold op until the transfer.
- Outputs are registered; there is no combinational path from op to any output.

Test Plan:
- Reset and idle: assert reset_n=0 mid-run, release -> all outputs 0 and op_ready=1 the next cycle; op_valid=0 for 10 cycles -> no change.
- Single addv, HOLD_CYCLES=2: transfer op=5 -> next 2 cycles alu_op=0, flags=110110, flags_valid=1, op_ready=0; then outputs 0, op_ready=1, retired=1.
- Back-to-back: op_valid held with ops 2,3,6,10 -> transfers spaced 3 cycles apart, each with its listed flags/alu_op (subr: 1/111111; orr: 3/111111); retired=4. A nop in the stream gives flags_valid=0 and still increments retired.
- Halt: after 2 ops send op=0 -> halted=1 the next cycle, op_ready=0 permanently; further op_valid does not change retired (stays 2) or any output; reset clears.
- Fault: op=13 -> fault=1, fault_op=13, halted=0, retired unchanged; reset asserted during EXEC of subv -> outputs 0 immediately, retired not incremented.
- Saturation with CNT_W=3: 9 nops -> retired reads 7 after the 7th nop and stays 7.
